digit_sequencer: RTL
====================

# digit_sequencer

Plays the fixed nine-digit student-number sequence (0,8,0,8,3,9,0,2,2) on one seven-segment display, one digit at a time, with a blank gap between digits. A single start/stop control runs it, and playback can repeat continuously. The block owns a `seven_segment_driver` and acts as its sequencer: it chooses the digit the driver renders and when the display blanks. It sits between board switches/keys and one `HEX` output.

## Interface
- `SHOW_CYCLES`, default 25_000_000: clock cycles each digit is displayed. Must be ≥1.
- `GAP_CYCLES`, default 5_000_000: blank cycles after each digit. 0 means no gap.
- `NUM_DIGITS`, default 9: sequence length. Must be ≤ the package table length.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: level input from a switch or key. A rising edge starts a run.
- `stop`, in, 1: level input. While high, aborts any run and holds the block idle.
- `loop_en`, in, 1: when high at the end of a sequence, playback restarts at digit 0.
- `DISP`, out, 8: active-low segments, bit 7 = DP. `8'hFF` = blank.
- `busy`, out, 1: high in SHOW or GAP.
- `digit_idx`, out, 4: index of the current or last digit shown.
- `done`, out, 1: one-cycle pulse on natural completion.

## Operation
- FSM states: IDLE, SHOW, GAP.
- Start detection:
  - `start_q` is a registered copy of `start`.
  - A start event is `start & ~start_q`.
  - `start_q` resets to 1, so a `start` held high through reset does not trigger a run; it must go low, then high.
- IDLE:
  - `DISP` = `8'hFF`, `busy` = 0.
  - On a start event with `stop` low: go to SHOW with idx = 0 and cnt = 0.
- SHOW:
  - `DISP` = driver output for `DIGIT_SEQ[idx]`; the DP bit is passed through from the driver.
  - When cnt = SHOW_CYCLES−1, clear cnt, then:
    - if GAP_CYCLES > 0: go to GAP;
    - otherwise: take the advance step directly.
- GAP:
  - `DISP` = `8'hFF`.
  - When cnt = GAP_CYCLES−1, clear cnt and take the advance step.
- Advance step:
  - If idx < NUM_DIGITS−1: idx+1, go to SHOW.
  - Else if `loop_en`: idx = 0, go to SHOW, no `done`.
  - Else: go to IDLE, assert `done` for one cycle, keep idx.
- `stop` high in any state: next state is IDLE, cnt cleared, idx kept, no `done`. `stop` has priority over a same-cycle start event and over the advance step.
- A start event while `busy` is ignored; a run is never restarted mid-sequence.
- `loop_en` is sampled only at the advance step of the last digit.
- The digit value goes through `seven_segment_driver.num_in` (4 bits). Its output `seg_out` is muxed with the blank value to form `DISP`.

## Timing
- Reset values: state IDLE, idx 0, cnt 0, `start_q` 1, `done` 0, `busy` 0, `DISP` `8'hFF`, `digit_idx` 0.
- `DISP`, `busy` and `digit_idx` are combinational from registered state. `done` is registered.
- Start latency:
  - a start event sampled at edge k makes state SHOW after edge k;
  - digit 0 is visible from edge k until edge k+SHOW_CYCLES.
- Each digit: exactly SHOW_CYCLES cycles visible, then exactly GAP_CYCLES cycles blank.
- A full non-looping run keeps `busy` high for NUM_DIGITS×(SHOW_CYCLES+GAP_CYCLES) cycles. The last gap is included.
- `done` is high in the first IDLE cycle after the run.
- `stop` sampled at edge k: blank and `busy` = 0 from edge k onward.
- `reset` mid-run: the block is in IDLE after the edge, with all reset values, regardless of other inputs.
- Counter width is $clog2(max(SHOW_CYCLES, GAP_CYCLES, 2)). The counter never wraps past its terminal value.

## Structure
- Package `digit_seq_pkg`:
  - `DIGIT_SEQ`, a constant 9×4-bit table holding 0,8,0,8,3,9,0,2,2;
  - `BLANK` = `8'hFF`;
  - the state enum `seq_state_t` (IDLE, SHOW, GAP).
- Sub-module: one instance of the existing `seven_segment_driver`. The FSM, counter and edge detect are in `digit_sequencer` itself.

## Test plan
All scenarios use SHOW_CYCLES = 4 and GAP_CYCLES = 2.
- Reset, then a `start` pulse with `loop_en` = 0 → `DISP` shows the encodings of 0,8,0,8,3,9,0,2,2, each for 4 cycles, with `8'hFF` for 2 cycles between digits; `busy` is high for 54 cycles; one `done` pulse follows; then idle blank.
- `start` held high through reset deassert → no run. Drop `start` low, then raise it → the run begins on that edge.
- `stop` asserted during the third digit's SHOW → `DISP` = `8'hFF` and `busy` = 0 from the next edge, no `done`, `digit_idx` = 2.
- `loop_en` = 1 → after digit 8's gap, digit 0 is shown again, no `done`. Drop `loop_en` → the next completion gives `done`.
- `start` and `stop` rising in the same cycle → stays IDLE. A second start event during a run → ignored; the cycle counts are unchanged.
- `GAP_CYCLES` = 0 build → digits play back-to-back with no blank; the run is 36 busy cycles.

Source files
------------

// File: rtl/digit_seq_pkg.sv
// Shared constants for the digit sequencer: digit table, blank code, FSM states.
package digit_seq_pkg;

    localparam int unsigned SEQ_LEN = 9;

    localparam logic [3:0] DIGIT_SEQ [0:SEQ_LEN-1] = '{
        4'd0, 4'd8, 4'd0, 4'd8, 4'd3, 4'd9, 4'd0, 4'd2, 4'd2
    };

    localparam logic [7:0] BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    // Largest of three cycle counts; sizes the shared show/gap counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seven_segment_driver.sv
// Hex digit to active-low seven-segment encoding, bit 7 = DP (kept off).
module seven_segment_driver (
    input  logic [3:0] num_in,
    output logic [7:0] seg_out
);

    // seg_out[6:0] = g,f,e,d,c,b,a; a zero lights the segment.
    always_comb begin
        seg_out = 8'hFF;
        case (num_in)
            4'h0: seg_out = 8'hC0;
            4'h1: seg_out = 8'hF9;
            4'h2: seg_out = 8'hA4;
            4'h3: seg_out = 8'hB0;
            4'h4: seg_out = 8'h99;
            4'h5: seg_out = 8'h92;
            4'h6: seg_out = 8'h82;
            4'h7: seg_out = 8'hF8;
            4'h8: seg_out = 8'h80;
            4'h9: seg_out = 8'h90;
            4'hA: seg_out = 8'h88;
            4'hB: seg_out = 8'h83;
            4'hC: seg_out = 8'hC6;
            4'hD: seg_out = 8'hA1;
            4'hE: seg_out = 8'h86;
            4'hF: seg_out = 8'h8E;
            default: seg_out = 8'hFF;
        endcase
    end

endmodule

// File: rtl/digit_sequencer.sv
// Plays the fixed digit table on one seven-segment display with blank gaps,
// started by a rising edge on start, aborted by stop, optionally looping.
module digit_sequencer
    import digit_seq_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000,
    parameter int unsigned NUM_DIGITS  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [7:0] DISP,
    output logic       busy,
    output logic [3:0] digit_idx,
    output logic       done
);

    localparam int unsigned CW = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, 2));
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]    IDX_LAST  = 4'(NUM_DIGITS - 1);

    seq_state_t    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q;
    logic          done_q, done_d;
    logic          start_evt;
    logic [7:0]    seg;

    assign start_evt = start & ~start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            start_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_evt) begin
                        state_d = SHOW;
                        idx_d   = 4'd0;
                        cnt_d   = '0;
                    end
                end
                SHOW, GAP: begin
                    if ((state_q == SHOW && cnt_q == SHOW_LAST) ||
                        (state_q == GAP  && cnt_q == GAP_LAST)) begin
                        cnt_d = '0;
                        if (state_q == SHOW && GAP_CYCLES > 0) begin
                            state_d = GAP;
                        end else if (idx_q < IDX_LAST) begin
                            // Advance step: next digit, wrap, or finish.
                            idx_d   = idx_q + 4'd1;
                            state_d = SHOW;
                        end else if (loop_en) begin
                            idx_d   = 4'd0;
                            state_d = SHOW;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    seven_segment_driver u_seg (
        .num_in  (DIGIT_SEQ[idx_q]),
        .seg_out (seg)
    );

    assign DISP      = (state_q == SHOW) ? seg : BLANK;
    assign busy      = (state_q != IDLE);
    assign digit_idx = idx_q;
    assign done      = done_q;

endmodule
